mcycle_unit: RTL and testbench
==============================

Name: mcycle_unit

Overview:
- Iterative multiply/divide responder for the single-cycle ARM core's control path.
- The control unit/datapath (initiator) raises Start with an operation code and two operands, then stalls the PC while Busy is high.
- This block (responder) computes the result over WIDTH iterations, drops Busy, and holds registered results until the next accepted Start.

Parameters:
- WIDTH, 32, operand/result width in bits; also the iteration count.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESETn  input  1  asynchronous, active-low reset.
- Start  input  1  request from the control unit; sampled only in IDLE.
- MCycleOp  input  2  bit0: 0 = multiply, 1 = divide; bit1: 0 = unsigned, 1 = signed.
- Operand1  input  WIDTH  multiplicand / dividend.
- Operand2  input  WIDTH  multiplier / divisor.
- Result1  output  WIDTH  product low word / quotient.
- Result2  output  WIDTH  product high word / remainder.
- Busy  output  1  stall request to the initiator.
- Done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (RESETn=0, asynchronous): state=IDLE, counter=0, Result1=0, Result2=0, Done=0, Busy=0.
- States:
  - IDLE: Start=1 at a rising edge latches MCycleOp, |Operand1| and |Operand2| (absolute values only when bit1=1), and the result sign bits, then moves to COMPUTE with count=0. Start=0 stays in IDLE.
  - COMPUTE: one iteration per cycle; count increments. At the edge where count==WIDTH-1, apply sign correction, write Result1/Result2, pulse Done, and return to IDLE.
- Busy is combinational: Busy = (IDLE & Start) | COMPUTE. It is high in the same cycle Start is first asserted, so the initiator stalls without a cycle of slip.
- Latency: Start asserted in cycle 0.
  - Busy is high in cycles 0..WIDTH (WIDTH+1 cycles).
  - Busy is low and Done=1 in cycle WIDTH+1.
  - Results are valid from cycle WIDTH+1 and held until the next accepted Start completes.
- Done is registered. It is high for exactly one cycle unless a new operation completes back-to-back.
- Multiply: shift-add over a 2*WIDTH accumulator, LSB-first on the multiplier. The final unsigned product is negated (two's complement, 2*WIDTH bits) if signed and the operand signs differ. Result2 = upper WIDTH bits, Result1 = lower WIDTH bits.
- Divide: restoring division, MSB-first, with a WIDTH+1-bit partial remainder.
  - Quotient is negated if signed and the signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero:
  - Unsigned: Result1 = all ones, Result2 = Operand1.
  - Signed: the same raw result (all ones magnitude path), then the sign rules above apply.
  - No exception is raised and latency is unchanged.
- Signed overflow (-2^(WIDTH-1) / -1): Result1 = 2^(WIDTH-1) pattern (0x80000000), Result2 = 0.
- Operand and MCycleOp changes after the accepting edge are ignored.
- Start held high through completion starts a new operation only on the cycle after Done, where Busy re-asserts combinationally. Start in COMPUTE is ignored.
- Reset mid-operation aborts immediately: outputs return to reset values and no Done pulse is issued.
- Results are never partially updated; Result1/Result2 change only at the completing edge or on reset.

Test Plan:
- Unsigned multiply: Op=00, Operand1=0xFFFFFFFF, Operand2=0x00000002 -> Busy high 33 cycles including the Start cycle; then Result2=0x00000001, Result1=0xFFFFFFFE, Done pulses once.
- Signed multiply: Op=10, Operand1=0xFFFFFFFD (-3), Operand2=0x00000007 -> Result2=0xFFFFFFFF, Result1=0xFFFFFFEB (-21).
- Divide:
  - Op=01, 100/7 -> Result1=14, Result2=2.
  - Op=11, -100/7 -> Result1=0xFFFFFFF2 (-14), Result2=0xFFFFFFFE (-2).
  - Op=11, 0x80000000/0xFFFFFFFF -> Result1=0x80000000, Result2=0.
- Divide by zero: Op=01, Operand1=0x12345678, Operand2=0 -> Result1=0xFFFFFFFF, Result2=0x12345678, latency still 33 Busy cycles.
- Handshake:
  - Start held high for 70 cycles -> two complete operations; Busy drops for exactly the Done cycle between them, then re-asserts.
  - Operand changes mid-COMPUTE do not alter results.
- Reset: assert RESETn=0 at cycle 10 of a multiply -> Busy, Done, Result1 and Result2 all go to 0 immediately. A Start after release completes normally in 33 cycles.

Source files
------------

// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Busy stalls the initiator from the cycle Start is first raised until the result is written.
module mcycle_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPUTE = 1'b1
    } state_t;

    state_t               state;
    logic [CW-1:0]        count;
    logic                 is_div;
    logic                 neg_q;
    logic                 neg_r;
    logic [WIDTH-1:0]     opb;
    logic [WIDTH-1:0]     acc_hi;
    logic [WIDTH-1:0]     acc_lo;

    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic                 accept;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH+1:0]     div_trial;
    logic                 div_ok;
    logic [WIDTH-1:0]     nxt_hi;
    logic [WIDTH-1:0]     nxt_lo;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     q_s;
    logic [WIDTH-1:0]     r_s;
    logic [WIDTH-1:0]     res1;
    logic [WIDTH-1:0]     res2;

    // A Start seen in the completion cycle waits one cycle so Busy visibly drops for Done.
    assign accept = (state == IDLE) && Start && !Done;
    assign Busy   = accept || (state == COMPUTE);

    // Operand magnitudes and sign capture for the signed variants
    always_comb begin
        a_neg = MCycleOp[1] & Operand1[WIDTH-1];
        b_neg = MCycleOp[1] & Operand2[WIDTH-1];
        abs_a = a_neg ? -Operand1 : Operand1;
        abs_b = b_neg ? -Operand2 : Operand2;
    end

    // One iteration of either algorithm plus the sign-corrected final result
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, opb};
        div_ok    = ~div_trial[WIDTH+1];
        nxt_hi    = mul_sum[WIDTH:1];
        nxt_lo    = {mul_sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            nxt_hi = div_ok ? WIDTH'(div_trial[WIDTH:0]) : WIDTH'(div_shift);
            nxt_lo = {acc_lo[WIDTH-2:0], div_ok};
        end
        prod   = {nxt_hi, nxt_lo};
        prod_s = neg_q ? -prod : prod;
        q_s    = neg_q ? -nxt_lo : nxt_lo;
        r_s    = neg_r ? -nxt_hi : nxt_hi;
        res1   = is_div ? q_s : prod_s[WIDTH-1:0];
        res2   = is_div ? r_s : prod_s[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state   <= IDLE;
            count   <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            opb     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            Result1 <= '0;
            Result2 <= '0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= COMPUTE;
                        count  <= '0;
                        is_div <= MCycleOp[0];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        acc_hi <= '0;
                        // Divide: shift the dividend out against the divisor.
                        // Multiply: walk the multiplier while adding the multiplicand.
                        opb    <= MCycleOp[0] ? abs_b : abs_a;
                        acc_lo <= MCycleOp[0] ? abs_a : abs_b;
                    end
                end
                COMPUTE: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    count  <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state   <= IDLE;
                        Done    <= 1'b1;
                        Result1 <= res1;
                        Result2 <= res2;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_unit.sv
// Bench for mcycle_unit: directed cases, random operations against an arithmetic reference,
// handshake timing with Start held high, and asynchronous reset mid-operation.
module tb_mcycle_unit;

    localparam int unsigned W = 32;

    logic         CLK = 1'b0;
    logic         RESETn;
    logic         Start;
    logic [1:0]   MCycleOp;
    logic [W-1:0] Operand1;
    logic [W-1:0] Operand2;
    logic [W-1:0] Result1;
    logic [W-1:0] Result2;
    logic         Busy;
    logic         Done;

    int total = 0;
    int bad   = 0;

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference computed with plain wide arithmetic
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] r1, output logic [W-1:0] r2);
        longint       sa, sb, sq, sr;
        logic [63:0]  p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op[0]) begin
            if (op[1]) p = 64'(sa * sb);
            else       p = 64'(a) * 64'(b);
            r1 = p[31:0];
            r2 = p[63:32];
        end else if (b == '0) begin
            r2 = a;
            r1 = (op[1] && a[W-1]) ? 32'd1 : 32'hFFFF_FFFF;
        end else if (op[1]) begin
            sq = sa / sb;
            sr = sa % sb;
            r1 = 32'(sq);
            r2 = 32'(sr);
        end else begin
            r1 = a / b;
            r2 = a % b;
        end
    endfunction

    // One full operation from an idle, non-Done cycle; optionally scrambles inputs after acceptance
    task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit scramble);
        logic [W-1:0] e1, e2;
        int busy_cnt;
        int n;
        model(op, a, b, e1, e2);
        Start    = 1'b1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        #1;
        busy_cnt = Busy ? 1 : 0;
        n = 0;
        while (n < 100) begin
            tick();
            Start = 1'b0;
            if (scramble) begin
                MCycleOp = 2'($urandom_range(0, 3));
                Operand1 = $urandom;
                Operand2 = $urandom;
            end
            if (!Busy) break;
            busy_cnt++;
            n++;
        end
        chk({tag, ".busy_cycles"}, W'(busy_cnt), W'(W + 1));
        chk({tag, ".done"}, W'(Done), W'(1));
        chk({tag, ".r1"}, Result1, e1);
        chk({tag, ".r2"}, Result2, e2);
        tick();
        chk({tag, ".done_low"}, W'(Done), W'(0));
        chk({tag, ".r1_hold"}, Result1, e1);
    endtask

    initial begin
        logic [W-1:0] e1, e2;
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        int           done_cnt;

        RESETn   = 1'b0;
        Start    = 1'b0;
        MCycleOp = 2'b00;
        Operand1 = '0;
        Operand2 = '0;
        tick();
        chk("reset.busy", W'(Busy), W'(0));
        chk("reset.done", W'(Done), W'(0));
        chk("reset.r1", Result1, '0);
        chk("reset.r2", Result2, '0);
        tick();
        RESETn = 1'b1;
        tick();
        chk("idle.busy", W'(Busy), W'(0));

        do_op("umul", 2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        do_op("smul", 2'b10, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
        do_op("udiv", 2'b01, 32'd100, 32'd7, 1'b0);
        do_op("sdiv", 2'b11, -32'sd100, 32'd7, 1'b0);
        do_op("sovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("udiv0", 2'b01, 32'h1234_5678, 32'h0, 1'b0);
        do_op("sdiv0", 2'b11, 32'hFFFF_FFFB, 32'h0, 1'b0);
        do_op("scram", 2'b11, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);

        // Start held for 70 cycles: accept, complete, skip the Done cycle, accept again
        MCycleOp = 2'b00;
        Operand1 = 32'h0001_0003;
        Operand2 = 32'h0000_0101;
        model(2'b00, Operand1, Operand2, e1, e2);
        Start = 1'b1;
        #1;
        done_cnt = 0;
        for (int k = 0; k < 70; k++) begin
            chk($sformatf("held.busy%0d", k), W'(Busy), W'((k % (W + 2)) != (W + 1)));
            chk($sformatf("held.done%0d", k), W'(Done), W'((k % (W + 2)) == (W + 1)));
            if (Done) begin
                done_cnt++;
                chk($sformatf("held.r1_%0d", k), Result1, e1);
                chk($sformatf("held.r2_%0d", k), Result2, e2);
            end
            tick();
        end
        Start = 1'b0;
        chk("held.done_count", W'(done_cnt), W'(2));
        for (int k = 0; k < 100 && !Done; k++) tick();
        chk("held.third_done", W'(Done), W'(1));
        tick();

        // Random operations
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom;
            endcase
            do_op($sformatf("rnd%0d", i), rop, ra, rb, 1'(i % 2));
        end

        // Reset at cycle 10 of a multiply aborts with no Done
        Start    = 1'b1;
        MCycleOp = 2'b00;
        Operand1 = 32'h0000_1111;
        Operand2 = 32'h0000_2222;
        for (int k = 0; k < 10; k++) begin
            tick();
            Start = 1'b0;
        end
        RESETn = 1'b0;
        #1;
        chk("abort.busy", W'(Busy), W'(0));
        chk("abort.done", W'(Done), W'(0));
        chk("abort.r1", Result1, '0);
        chk("abort.r2", Result2, '0);
        tick();
        RESETn = 1'b1;
        tick();
        chk("abort.no_done", W'(Done), W'(0));
        do_op("post_reset", 2'b00, 32'h0000_1111, 32'h0000_2222, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
